ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Drives the open-drain PS/2 clock and data lines through active-low drive enables and runs the host request-to-send sequence.
- Checks the device ACK and reports completion with a status code.
- Sits beside the PS/2 receiver on the same lines; `tx_busy` tells the receiver to ignore traffic while a command is in flight.

---
 rtl/ps2_host_tx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs the inhibit / request-to-send sequence on the open-drain PS/2 lines.
// Shifts out one command byte with odd parity and a stop bit.
// Checks the device ACK, and aborts when the device goes silent.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [1:0] tx_status,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_NO_ACK = 2'b01;
    localparam logic [1:0] ST_TMO    = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [INH_W-1:0]   inh_cnt, inh_cnt_n;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
    logic [3:0]         edge_cnt, edge_cnt_n;
    logic [9:0]         shift, shift_n;
    logic               ack_ok, ack_ok_n;
    logic               busy_n, done_n, clk_drv_n, data_drv_n;
    logic [1:0]         status_n;

    logic [1:0]         clk_sync, data_sync;
    logic               clk_prev;
    logic               clk_s, data_s;
    logic               fall_c, timeout_c, in_window_c;

    // Two-flop synchronizers on the read-back lines plus previous clock sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // State and datapath registers; outputs are registered copies of next values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            inh_cnt            <= '0;
            tmo_cnt            <= '0;
            edge_cnt           <= '0;
            shift              <= '0;
            ack_ok             <= 1'b0;
            tx_busy            <= 1'b0;
            tx_done            <= 1'b0;
            tx_status          <= ST_OK;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
        end else begin
            state              <= state_n;
            inh_cnt            <= inh_cnt_n;
            tmo_cnt            <= tmo_cnt_n;
            edge_cnt           <= edge_cnt_n;
            shift              <= shift_n;
            ack_ok             <= ack_ok_n;
            tx_busy            <= busy_n;
            tx_done            <= done_n;
            tx_status          <= status_n;
            ps2_clk_drive_low  <= clk_drv_n;
            ps2_data_drive_low <= data_drv_n;
        end
    end

    // Next-state, counters, shifter and line drive decisions
    always_comb begin
        state_n     = state;
        inh_cnt_n   = inh_cnt;
        tmo_cnt_n   = tmo_cnt;
        edge_cnt_n  = edge_cnt;
        shift_n     = shift;
        ack_ok_n    = ack_ok;
        done_n      = 1'b0;
        status_n    = tx_status;
        data_drv_n  = ps2_data_drive_low;
        busy_n      = 1'b0;
        clk_drv_n   = 1'b0;
        in_window_c = 1'b0;

        fall_c    = clk_prev & ~clk_s;
        timeout_c = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

        unique case (state)
            IDLE: begin
                data_drv_n = 1'b0;
                if (tx_start) begin
                    shift_n   = {1'b1, ~^tx_data, tx_data};
                    inh_cnt_n = '0;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_drv_n = 1'b1;
                    state_n    = REQ;
                end else begin
                    inh_cnt_n = inh_cnt + 1'b1;
                end
            end
            REQ: begin
                edge_cnt_n = '0;
                tmo_cnt_n  = '0;
                state_n    = SEND;
            end
            SEND: begin
                in_window_c = 1'b1;
                tmo_cnt_n   = tmo_cnt + 1'b1;
                if (fall_c) begin
                    data_drv_n = ~shift[0];
                    shift_n    = {1'b0, shift[9:1]};
                    edge_cnt_n = edge_cnt + 1'b1;
                    if (edge_cnt == 4'd9) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                in_window_c = 1'b1;
                tmo_cnt_n   = tmo_cnt + 1'b1;
                if (fall_c) begin
                    ack_ok_n = ~data_s;
                    state_n  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                in_window_c = 1'b1;
                tmo_cnt_n   = tmo_cnt + 1'b1;
                if (clk_s && data_s) begin
                    done_n   = 1'b1;
                    status_n = ack_ok ? ST_OK : ST_NO_ACK;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A silent device wins over any edge seen in the same cycle
        if (in_window_c && timeout_c) begin
            done_n   = 1'b1;
            status_n = ST_TMO;
            state_n  = IDLE;
        end

        if (state_n == IDLE) begin
            data_drv_n = 1'b0;
        end
        busy_n    = (state_n != IDLE);
        clk_drv_n = (state_n == INHIBIT) || (state_n == REQ);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic [1:0] tx_status;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       dev_clk;
    logic       dev_data;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int done_cnt = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_data            (tx_data),
        .tx_start           (tx_start),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .tx_status          (tx_status),
        .ps2_clk            (ps2_clk),
        .ps2_data           (ps2_data),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    // Wired-AND open-drain lines with pull-ups
    assign ps2_clk  = ~ps2_clk_drive_low & dev_clk;
    assign ps2_data = ~ps2_data_drive_low & dev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every tx_done pulse
    always @(posedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic start_cmd(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device model: waits for request-to-send, then clocks up to max_edges falling edges
    task automatic dev_clock(input bit do_ack, input int max_edges,
                             output logic [9:0] bits, output bit ok);
        int n;
        bits = '0;
        ok   = 1'b0;
        n    = 0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) return;
        ok = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == max_edges && max_edges < 11) begin
                repeat (10) @(negedge clk);
                return;
            end
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            if (i == 11) begin
                dev_data = 1'b1;
                return;
            end
            bits[i-1] = ps2_data;
            if (i == 10 && do_ack) begin
                repeat (5) @(negedge clk);
                dev_data = 1'b0;
                repeat (15) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
        end
    endtask

    // Waits (bounded) for tx_done and captures the outputs in that cycle
    task automatic wait_done(input int budget, output bit seen, output logic [1:0] st,
                             output logic busy, output logic cdrv, output logic ddrv);
        seen = 1'b0; st = 2'bxx; busy = 1'bx; cdrv = 1'bx; ddrv = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                seen = 1'b1; st = tx_status; busy = tx_busy;
                cdrv = ps2_clk_drive_low; ddrv = ps2_data_drive_low;
                return;
            end
        end
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit do_ack, output logic [9:0] bits,
                            output bit ok, output bit seen, output logic [1:0] st);
        logic b, c, e;
        start_cmd(d);
        dev_clock(do_ack, 11, bits, ok);
        wait_done(200, seen, st, b, c, e);
    endtask

    task automatic test_reset;
        @(negedge clk);
        vec_cnt++; if (tx_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        vec_cnt++; if (tx_done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", tx_done); end
        vec_cnt++; if (tx_status !== 2'b00) begin err_cnt++; $display("FAIL reset_status: got %b want 00", tx_status); end
        vec_cnt++; if (ps2_clk_drive_low !== 1'b0) begin err_cnt++; $display("FAIL reset_clk_drv: got %b want 0", ps2_clk_drive_low); end
        vec_cnt++; if (ps2_data_drive_low !== 1'b0) begin err_cnt++; $display("FAIL reset_data_drv: got %b want 0", ps2_data_drive_low); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ed_ack;
        int cnt, d0;
        logic [9:0] bits;
        bit ok, seen;
        logic [1:0] st;
        logic b, c, e;
        d0 = done_cnt;
        start_cmd(8'hED);
        vec_cnt++; if (tx_busy !== 1'b1) begin err_cnt++; $display("FAIL ed_busy_after_accept: got %b want 1", tx_busy); end
        cnt = 0;
        while (ps2_clk_drive_low === 1'b1 && ps2_data_drive_low === 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        vec_cnt++; if (cnt != 20) begin err_cnt++; $display("FAIL ed_inhibit_len: got %0d want 20", cnt); end
        vec_cnt++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b11) begin err_cnt++; $display("FAIL ed_req: got %b want 11", {ps2_clk_drive_low, ps2_data_drive_low}); end
        @(negedge clk);
        vec_cnt++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b01) begin err_cnt++; $display("FAIL ed_start_bit: got %b want 01", {ps2_clk_drive_low, ps2_data_drive_low}); end
        dev_clock(1'b1, 11, bits, ok);
        vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL ed_rts_seen: got %b want 1", ok); end
        vec_cnt++; if (bits !== 10'b1_1_11101101) begin err_cnt++; $display("FAIL ed_bits: got %b want 1111101101", bits); end
        wait_done(200, seen, st, b, c, e);
        vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL ed_done_timeout: got %b want 1", seen); end
        vec_cnt++; if (st !== 2'b00) begin err_cnt++; $display("FAIL ed_status: got %b want 00", st); end
        vec_cnt++; if (b !== 1'b0) begin err_cnt++; $display("FAIL ed_busy_at_done: got %b want 0", b); end
        @(negedge clk);
        vec_cnt++; if (tx_done !== 1'b0) begin err_cnt++; $display("FAIL ed_done_width: got %b want 0", tx_done); end
        repeat (20) @(negedge clk);
        vec_cnt++; if (done_cnt - d0 != 1) begin err_cnt++; $display("FAIL ed_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_parity;
        logic [9:0] bits;
        bit ok, seen;
        logic [1:0] st;
        run_xfer(8'h07, 1'b1, bits, ok, seen, st);
        vec_cnt++; if (bits !== 10'b1_0_00000111) begin err_cnt++; $display("FAIL par07_bits: got %b want 1000000111", bits); end
        vec_cnt++; if (!seen || st !== 2'b00) begin err_cnt++; $display("FAIL par07_status: got seen=%b st=%b want seen=1 st=00", seen, st); end
        repeat (10) @(negedge clk);
        run_xfer(8'h00, 1'b1, bits, ok, seen, st);
        vec_cnt++; if (bits !== 10'b1_1_00000000) begin err_cnt++; $display("FAIL par00_bits: got %b want 1100000000", bits); end
        vec_cnt++; if (!seen || st !== 2'b00) begin err_cnt++; $display("FAIL par00_status: got seen=%b st=%b want seen=1 st=00", seen, st); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_no_ack;
        logic [9:0] bits;
        bit ok, seen;
        logic [1:0] st;
        logic b, c, e;
        int d0;
        d0 = done_cnt;
        start_cmd(8'hED);
        dev_clock(1'b0, 11, bits, ok);
        wait_done(200, seen, st, b, c, e);
        vec_cnt++; if (!seen || st !== 2'b01) begin err_cnt++; $display("FAIL noack_status: got seen=%b st=%b want seen=1 st=01", seen, st); end
        vec_cnt++; if ({c, e} !== 2'b00) begin err_cnt++; $display("FAIL noack_release: got %b want 00", {c, e}); end
        repeat (20) @(negedge clk);
        vec_cnt++; if (done_cnt - d0 != 1) begin err_cnt++; $display("FAIL noack_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_timeout_back_to_back;
        int n;
        logic [9:0] bits;
        bit ok, seen;
        logic [1:0] st;
        logic b, c, e;
        start_cmd(8'hED);
        n = 0;
        while (ps2_clk_drive_low !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (tx_done !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
        vec_cnt++; if (n != 5000) begin err_cnt++; $display("FAIL tmo_latency: got %0d want 5000", n); end
        vec_cnt++; if (tx_status !== 2'b10) begin err_cnt++; $display("FAIL tmo_status: got %b want 10", tx_status); end
        vec_cnt++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin err_cnt++; $display("FAIL tmo_release: got %b want 00", {ps2_clk_drive_low, ps2_data_drive_low}); end
        vec_cnt++; if (tx_busy !== 1'b0) begin err_cnt++; $display("FAIL tmo_busy: got %b want 0", tx_busy); end
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        vec_cnt++; if (tx_busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept: got %b want 1", tx_busy); end
        dev_clock(1'b1, 11, bits, ok);
        wait_done(200, seen, st, b, c, e);
        vec_cnt++; if (bits !== 10'b1_1_11111111) begin err_cnt++; $display("FAIL b2b_bits: got %b want 1111111111", bits); end
        vec_cnt++; if (!seen || st !== 2'b00) begin err_cnt++; $display("FAIL b2b_status: got seen=%b st=%b want seen=1 st=00", seen, st); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_ignore_start;
        logic [9:0] bits;
        bit ok, seen;
        logic [1:0] st;
        logic b, c, e;
        int d0;
        d0 = done_cnt;
        start_cmd(8'hED);
        fork
            dev_clock(1'b1, 11, bits, ok);
            begin
                repeat (3) @(negedge clk);
                tx_data = 8'h55; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (120) @(negedge clk);
                tx_data = 8'h33; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_done(200, seen, st, b, c, e);
        vec_cnt++; if (bits !== 10'b1_1_11101101) begin err_cnt++; $display("FAIL ign_bits: got %b want 1111101101", bits); end
        vec_cnt++; if (!seen || st !== 2'b00) begin err_cnt++; $display("FAIL ign_status: got seen=%b st=%b want seen=1 st=00", seen, st); end
        repeat (60) @(negedge clk);
        vec_cnt++; if (done_cnt - d0 != 1) begin err_cnt++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - d0); end
        vec_cnt++; if (tx_busy !== 1'b0) begin err_cnt++; $display("FAIL ign_idle_after: got %b want 0", tx_busy); end
    endtask

    task automatic test_reset_mid_send;
        logic [9:0] bits;
        bit ok, seen;
        logic [1:0] st;
        int d0;
        d0 = done_cnt;
        start_cmd(8'hED);
        dev_clock(1'b1, 5, bits, ok);
        vec_cnt++; if (ps2_data_drive_low !== 1'b1) begin err_cnt++; $display("FAIL rstmid_bit4_drive: got %b want 1", ps2_data_drive_low); end
        #2 rst = 1'b1;
        #1;
        vec_cnt++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin err_cnt++; $display("FAIL rstmid_async_release: got %b want 00", {ps2_clk_drive_low, ps2_data_drive_low}); end
        vec_cnt++; if (tx_busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        dev_clk = 1'b1;
        repeat (100) @(negedge clk);
        vec_cnt++; if (done_cnt != d0) begin err_cnt++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
        run_xfer(8'h5A, 1'b1, bits, ok, seen, st);
        vec_cnt++; if (bits !== 10'b1_1_01011010) begin err_cnt++; $display("FAIL rstmid_next_bits: got %b want 1101011010", bits); end
        vec_cnt++; if (!seen || st !== 2'b00) begin err_cnt++; $display("FAIL rstmid_next_status: got seen=%b st=%b want seen=1 st=00", seen, st); end
    endtask

    initial begin
        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        test_reset;
        test_ed_ack;
        test_parity;
        test_no_ack;
        test_timeout_back_to_back;
        test_ignore_start;
        test_reset_mid_send;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
